// File: rtl/keypad_encoder.sv
// ---------------------------------------------------------------------------
// keypad_encoder
//
// Scans a 4x4 matrix keypad, debounces presses and releases, and hands each
// accepted key to a controller as a command token with a consume handshake.
//
// Ports
//   Clock   in   1      single clock, all flops on posedge
//   Reset   in   1      asynchronous active-low reset
//   kp_row  out  4      row drive, active-low one-hot
//   kp_col  in   4      column sense, active-low, pulled up, asynchronous
//   in_cmd  out  IC_N   command token, `IC_NONE when nothing is pending
//   in_ack  in   1      consume strobe for the token shown on in_cmd
//
// Parameters
//   SETTLE_CYC    cycles a row is driven before columns are sampled
//   DEBOUNCE_CYC  cycles a column must be stable to count as press/release
//
// Build option
//   KEYPAD_FIFO_EN  defined: 4-entry token FIFO
//                   undefined: single holding register, new keys dropped
//                   while a token is pending
// ---------------------------------------------------------------------------

`ifndef IC_N
`define IC_N    5
`define IC_NONE 5'd0
`define IC_NUM0 5'd1
`define IC_NUM1 5'd2
`define IC_NUM2 5'd3
`define IC_NUM3 5'd4
`define IC_NUM4 5'd5
`define IC_NUM5 5'd6
`define IC_NUM6 5'd7
`define IC_NUM7 5'd8
`define IC_NUM8 5'd9
`define IC_NUM9 5'd10
`define IC_PLUS 5'd11
`define IC_MINS 5'd12
`define IC_MULT 5'd13
`define IC_DIVI 5'd14
`define IC_CLBK 5'd15
`define IC_CLCL 5'd16
`endif

module keypad_encoder #(
    parameter int SETTLE_CYC   = 3,
    parameter int DEBOUNCE_CYC = 200
) (
    input  logic             Clock,
    input  logic             Reset,
    output logic [3:0]       kp_row,
    input  logic [3:0]       kp_col,
    output logic [`IC_N-1:0] in_cmd,
    input  logic             in_ack
);

    localparam int SET_W = (SETTLE_CYC < 1) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam int DEB_W = (DEBOUNCE_CYC < 1) ? 1 : $clog2(DEBOUNCE_CYC + 1);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

    function automatic logic [DEB_W-1:0] sat_inc(input logic [DEB_W-1:0] v);
        return (v == {DEB_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    // Lowest-index active (low) column wins when several read low.
    function automatic logic [1:0] lowest_low(input logic [3:0] c);
        if (!c[0])      return 2'd0;
        else if (!c[1]) return 2'd1;
        else if (!c[2]) return 2'd2;
        else            return 2'd3;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        case (idx)
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1101;
            2'd2:    return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    function automatic logic [`IC_N-1:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: return `IC_NUM1;
            4'h1: return `IC_NUM2;
            4'h2: return `IC_NUM3;
            4'h3: return `IC_PLUS;
            4'h4: return `IC_NUM4;
            4'h5: return `IC_NUM5;
            4'h6: return `IC_NUM6;
            4'h7: return `IC_MINS;
            4'h8: return `IC_NUM7;
            4'h9: return `IC_NUM8;
            4'hA: return `IC_NUM9;
            4'hB: return `IC_MULT;
            4'hC: return `IC_CLBK;
            4'hD: return `IC_NUM0;
            4'hE: return `IC_CLCL;
            default: return `IC_DIVI;
        endcase
    endfunction

    state_t            state;
    logic [1:0]        row_idx;
    logic [1:0]        lat_row;
    logic [1:0]        lat_col;
    logic [SET_W-1:0]  settle_cnt;
    logic [DEB_W-1:0]  deb_cnt;
    logic [3:0]        col_p0;
    logic [3:0]        col_p1;
    logic              lat_hi;
    logic              enq;
    logic              deq;
    logic              accept;
    logic [`IC_N-1:0]  enq_code;

    // Stage p0/p1: two-flop synchronizer for the asynchronous column inputs.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            col_p0 <= '1;
            col_p1 <= '1;
        end else begin
            col_p0 <= kp_col;
            col_p1 <= col_p0;
        end
    end

    assign lat_hi   = col_p1[lat_col];
    assign enq      = (state == DEB_PRESS) && !lat_hi && (deb_cnt == DEB_W'(DEBOUNCE_CYC - 1));
    assign enq_code = key_code(lat_row, lat_col);
    assign deq      = in_ack && (in_cmd != `IC_NONE);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= SCAN;
            row_idx    <= 2'd0;
            kp_row     <= 4'b1110;
            settle_cnt <= '0;
            deb_cnt    <= '0;
            lat_row    <= 2'd0;
            lat_col    <= 2'd0;
        end else begin
            case (state)
                SCAN: begin
                    if (settle_cnt == SET_W'(SETTLE_CYC)) begin
                        settle_cnt <= '0;
                        if (col_p1 != 4'hF) begin
                            // Row stays driven; scanning resumes on this row if
                            // the press turns out to be a glitch.
                            lat_row <= row_idx;
                            lat_col <= lowest_low(col_p1);
                            deb_cnt <= '0;
                            state   <= DEB_PRESS;
                        end else begin
                            row_idx <= row_idx + 2'd1;
                            kp_row  <= row_drive(row_idx + 2'd1);
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (lat_hi) begin
                        deb_cnt <= '0;
                        state   <= SCAN;
                    end else if (enq) begin
                        deb_cnt <= '0;
                        state   <= HELD;
                    end else begin
                        deb_cnt <= sat_inc(deb_cnt);
                    end
                end
                HELD: begin
                    if (lat_hi) begin
                        deb_cnt <= '0;
                        state   <= DEB_REL;
                    end
                end
                DEB_REL: begin
                    if (!lat_hi) begin
                        deb_cnt <= '0;
                        state   <= HELD;
                    end else if (deb_cnt == DEB_W'(DEBOUNCE_CYC - 1)) begin
                        deb_cnt    <= '0;
                        settle_cnt <= '0;
                        row_idx    <= row_idx + 2'd1;
                        kp_row     <= row_drive(row_idx + 2'd1);
                        state      <= SCAN;
                    end else begin
                        deb_cnt <= sat_inc(deb_cnt);
                    end
                end
                default: state <= SCAN;
            endcase
        end
    end

`ifdef KEYPAD_FIFO_EN
    logic [`IC_N-1:0] mem [4];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [1:0]       nxt_rd;
    logic [2:0]       count;
    logic [2:0]       nxt_count;

    // A slot freed by a same-cycle consume makes room for the new key.
    assign accept    = enq && ((count != 3'd4) || deq);
    assign nxt_rd    = rd_ptr + {1'b0, deq};
    assign nxt_count = count + {2'b00, accept} - {2'b00, deq};

    always_ff @(posedge Clock) begin
        if (accept) mem[wr_ptr] <= enq_code;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            in_cmd <= `IC_NONE;
        end else begin
            wr_ptr <= wr_ptr + {1'b0, accept};
            rd_ptr <= nxt_rd;
            count  <= nxt_count;
            // Next head may be the entry being written this very cycle.
            if (nxt_count == 3'd0)
                in_cmd <= `IC_NONE;
            else if (accept && (wr_ptr == nxt_rd))
                in_cmd <= enq_code;
            else
                in_cmd <= mem[nxt_rd];
        end
    end
`else
    assign accept = enq && ((in_cmd == `IC_NONE) || deq);

    // in_cmd itself is the holding register; `IC_NONE marks it empty.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)
            in_cmd <= `IC_NONE;
        else if (accept)
            in_cmd <= enq_code;
        else if (deq)
            in_cmd <= `IC_NONE;
    end
`endif

endmodule

// File: tb/tb_keypad_encoder.sv
`ifndef IC_N
`define IC_N    5
`define IC_NONE 5'd0
`define IC_NUM0 5'd1
`define IC_NUM1 5'd2
`define IC_NUM2 5'd3
`define IC_NUM3 5'd4
`define IC_NUM4 5'd5
`define IC_NUM5 5'd6
`define IC_NUM6 5'd7
`define IC_NUM7 5'd8
`define IC_NUM8 5'd9
`define IC_NUM9 5'd10
`define IC_PLUS 5'd11
`define IC_MINS 5'd12
`define IC_MULT 5'd13
`define IC_DIVI 5'd14
`define IC_CLBK 5'd15
`define IC_CLCL 5'd16
`endif

module tb_keypad_encoder;
    localparam int SETTLE = 3;
    localparam int DEB    = 200;

    localparam logic [`IC_N-1:0] KEY_TBL [16] = '{
        `IC_NUM1, `IC_NUM2, `IC_NUM3, `IC_PLUS,
        `IC_NUM4, `IC_NUM5, `IC_NUM6, `IC_MINS,
        `IC_NUM7, `IC_NUM8, `IC_NUM9, `IC_MULT,
        `IC_CLBK, `IC_NUM0, `IC_CLCL, `IC_DIVI};

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic [3:0]       kp_row;
    logic [3:0]       kp_col;
    logic [`IC_N-1:0] in_cmd;
    logic             in_ack = 1'b0;
    logic [15:0]      pressed = '0;

    int errors = 0;
    int checks = 0;
    int vis_cnt = 0;
    logic [`IC_N-1:0] last_seen = `IC_NONE;
    logic [`IC_N-1:0] exp_q[$];

    keypad_encoder #(.SETTLE_CYC(SETTLE), .DEBOUNCE_CYC(DEB)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .kp_row(kp_row),
        .kp_col(kp_col),
        .in_cmd(in_cmd),
        .in_ack(in_ack)
    );

    always #5 Clock = ~Clock;

    // Keypad matrix: a pressed key pulls its column low while its row is driven.
    always_comb begin
        kp_col = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kp_row[r] && pressed[r*4+c]) kp_col[c] = 1'b0;
    end

    // Token stream model: every visible token must be the oldest expected one,
    // must stay put until acked, and is retired by the ack that consumed it.
    logic [`IC_N-1:0] prev_cmd = `IC_NONE;
    logic             prev_ack = 1'b0;
    logic             prev_vld = 1'b0;

    always @(negedge Clock) begin
        logic ok;
        if (!Reset) begin
            checks++;
            if (kp_row !== 4'b1110 || in_cmd !== `IC_NONE) begin
                errors++;
                $display("FAIL reset_hold: kp_row=%b in_cmd=%0d required kp_row=1110 in_cmd=%0d",
                         kp_row, in_cmd, `IC_NONE);
            end
            exp_q.delete();
            prev_vld = 1'b0;
        end else begin
            if (prev_vld && prev_cmd !== `IC_NONE && prev_ack && exp_q.size() > 0)
                void'(exp_q.pop_front());
            checks++;
            if (!(kp_row === 4'b1110 || kp_row === 4'b1101 ||
                  kp_row === 4'b1011 || kp_row === 4'b0111)) begin
                errors++;
                $display("FAIL row_onehot: kp_row=%b required one-hot-low", kp_row);
            end
            ok = 1'b1;
            if (in_cmd !== `IC_NONE) begin
                vis_cnt++;
                last_seen = in_cmd;
                if (exp_q.size() == 0) ok = 1'b0;
                else if (in_cmd !== exp_q[0]) ok = 1'b0;
            end
            if (prev_vld && prev_cmd !== `IC_NONE && !prev_ack && in_cmd !== prev_cmd) ok = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL cmd_stream: in_cmd=%0d required %0d (queue depth %0d, prev %0d)",
                         in_cmd, (exp_q.size() > 0) ? exp_q[0] : `IC_NONE, exp_q.size(), prev_cmd);
            end
            prev_cmd = in_cmd;
            prev_ack = in_ack;
            prev_vld = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic expect_key(input int idx);
`ifdef KEYPAD_FIFO_EN
        if (exp_q.size() < 4) exp_q.push_back(KEY_TBL[idx]);
`else
        if (exp_q.size() == 0) exp_q.push_back(KEY_TBL[idx]);
`endif
    endtask

    task automatic press(input int r, input int c, input int hold);
        expect_key(r*4 + c);
        pressed[r*4+c] = 1'b1;
        step(hold);
        pressed[r*4+c] = 1'b0;
        step(DEB + 40);
    endtask

    task automatic wait_row_change(output int n);
        logic [3:0] r0;
        r0 = kp_row;
        n  = 0;
        while (kp_row === r0 && n < 50) begin
            step(1);
            n++;
        end
    endtask

    task automatic ack_expect(input string name, input logic [`IC_N-1:0] req);
        int n;
        n = 0;
        while (in_cmd === `IC_NONE && n < 500) begin
            step(1);
            n++;
        end
        check(name, 32'(in_cmd), 32'(req));
        in_ack = 1'b1;
        step(1);
        in_ack = 1'b0;
        step(1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0] rot [3];
        rot = '{4'b1011, 4'b0111, 4'b1110};

        // Reset state
        #2 Reset = 1'b0;
        step(3);
        check("reset_kp_row", 32'(kp_row), 32'(4'b1110));
        check("reset_in_cmd", 32'(in_cmd), 32'(`IC_NONE));
        Reset = 1'b1;

        // Scan rotation and per-row hold time
        wait_row_change(n);
        check("scan_first_row", 32'(kp_row), 32'(4'b1101));
        for (int i = 0; i < 3; i++) begin
            wait_row_change(n);
            check("scan_hold", 32'(n), 32'(SETTLE + 1));
            check("scan_row", 32'(kp_row), 32'(rot[i]));
        end

        // Row1/col2 held 300 cycles with ack tied high: one NUM6 for one cycle
        in_ack  = 1'b1;
        vis_cnt = 0;
        press(1, 2, 300);
        check("num6_visible_cycles", 32'(vis_cnt), 32'd1);
        check("num6_code", 32'(last_seen), 32'(`IC_NUM6));
        check("num6_then_none", 32'(in_cmd), 32'(`IC_NONE));
        in_ack = 1'b0;

        // Row0/col0 glitch for 50 cycles: no token, scanning resumes
        vis_cnt = 0;
        pressed[0] = 1'b1;
        step(50);
        pressed[0] = 1'b0;
        step(5);
        wait_row_change(n);
        check("glitch_scan_resumes", 32'(n >= 1 && n <= SETTLE + 1), 32'd1);
        step(300);
        check("glitch_no_token", 32'(vis_cnt), 32'd0);
        check("glitch_in_cmd", 32'(in_cmd), 32'(`IC_NONE));

        // Row2 col0 and col3 together: lowest column wins
        expect_key(8);
        pressed[8]  = 1'b1;
        pressed[11] = 1'b1;
        step(300);
        check("multi_col_code", 32'(in_cmd), 32'(`IC_NUM7));
        pressed[8]  = 1'b0;
        pressed[11] = 1'b0;
        step(DEB + 40);
        ack_expect("multi_col_ack", `IC_NUM7);
        check("multi_col_empty", 32'(in_cmd), 32'(`IC_NONE));

        // Keys 1,2,3,+ with no ack: head stays NUM1
        press(0, 0, 300);
        press(0, 1, 300);
        press(0, 2, 300);
        press(0, 3, 300);
        check("seq_head_stable", 32'(in_cmd), 32'(`IC_NUM1));
        ack_expect("seq_ack0", `IC_NUM1);
`ifdef KEYPAD_FIFO_EN
        ack_expect("seq_ack1", `IC_NUM2);
        ack_expect("seq_ack2", `IC_NUM3);
        ack_expect("seq_ack3", `IC_PLUS);
`endif
        check("seq_drained", 32'(in_cmd), 32'(`IC_NONE));

        // Five presses without ack: overflow discarded
        press(1, 1, 300);
        press(1, 2, 300);
        press(2, 0, 300);
        press(2, 1, 300);
        press(2, 2, 300);
        ack_expect("ovf_ack0", `IC_NUM5);
`ifdef KEYPAD_FIFO_EN
        ack_expect("ovf_ack1", `IC_NUM6);
        ack_expect("ovf_ack2", `IC_NUM7);
        ack_expect("ovf_ack3", `IC_NUM8);
`endif
        step(5);
        check("ovf_drained", 32'(in_cmd), 32'(`IC_NONE));

        // Reset in the middle of debouncing key 5
        vis_cnt = 0;
        pressed[5] = 1'b1;
        step(100);
        check("deb_press_row_held", 32'(kp_row), 32'(4'b1101));
        Reset = 1'b0;
        #1;
        check("midrst_kp_row", 32'(kp_row), 32'(4'b1110));
        check("midrst_in_cmd", 32'(in_cmd), 32'(`IC_NONE));
        pressed[5] = 1'b0;
        step(3);
        Reset = 1'b1;
        step(DEB + 100);
        check("midrst_no_token", 32'(vis_cnt), 32'd0);
        check("midrst_final_cmd", 32'(in_cmd), 32'(`IC_NONE));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/keypad_encoder.md
KEYPAD_ENCODER -- requirements
Module: keypad_encoder

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 3: cycles each row is driven before columns are sampled.
REQ-002 SHALL have parameter DEBOUNCE_CYC, default 200: cycles a column reading must be stable to count as a press or a release.
REQ-003 SHALL have port Clock, input, 1, the single clock; all flops on posedge.
REQ-004 SHALL have port Reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port kp_row, output, 4, row drive, active-low one-hot.
REQ-006 SHALL have port kp_col, input, 4, column sense, active-low, externally pulled up, asynchronous to Clock.
REQ-007 SHALL have port in_cmd, output, `IC_N, command token to the controller; `IC_NONE when idle.
REQ-008 SHALL have port in_ack, input, 1, controller consume strobe.

Function
REQ-009 SHALL pass kp_col through a 2-flop synchronizer before any use.
REQ-010 SHALL implement FSM with states SCAN, DEB_PRESS, HELD, DEB_REL.
- SCAN: drive rows 0..3 in rotation.
- Each row is held SETTLE_CYC+1 cycles, and columns are sampled on the last cycle.
- Any sampled column low latches row and column and moves to DEB_PRESS.
REQ-011 SHALL resolve multiple active columns in DEB_PRESS to the lowest column index.
REQ-012 SHALL keep the latched row driven in DEB_PRESS.
- If the latched column stays low for DEBOUNCE_CYC consecutive cycles: enqueue the key code and go to HELD.
- If it goes high earlier: return to SCAN with no token.
REQ-013 SHALL wait in HELD until the latched column reads high, then go to DEB_REL.
REQ-014 SHALL go from DEB_REL to SCAN after DEBOUNCE_CYC consecutive high cycles.
- A low reading in DEB_REL restarts the count in HELD.
- No token is generated in DEB_REL.
REQ-015 SHALL map key (row,col) to codes as follows:
- row0: `IC_NUM1 `IC_NUM2 `IC_NUM3 `IC_PLUS
- row1: `IC_NUM4 `IC_NUM5 `IC_NUM6 `IC_MINS
- row2: `IC_NUM7 `IC_NUM8 `IC_NUM9 `IC_MULT
- row3: `IC_CLBK `IC_NUM0 `IC_CLCL `IC_DIVI
REQ-016 SHALL present in_cmd from a registered output token.
- A token is present whenever the buffer is non-empty; in_cmd = `IC_NONE otherwise.
- The token is visible the cycle after enqueue.
REQ-017 SHALL consume the token at a posedge where in_ack=1 and in_cmd!=`IC_NONE.
- The next cycle shows the next buffered token or `IC_NONE.
- in_ack while in_cmd=`IC_NONE has no effect.
REQ-018 SHALL hold in_cmd stable until consumed; a token is never presented twice and never dropped once visible.
REQ-019 SHALL enqueue first, then dequeue when an enqueue and a consume coincide in the same cycle, with no loss.
REQ-020 SHALL discard a new key when the buffer is full; the FSM still proceeds to HELD.
REQ-021 SHALL use saturating debounce counters, at least clog2(DEBOUNCE_CYC+1) bits wide, with no wrap.

Reset
REQ-022 SHALL, while Reset=0:
- put the FSM in SCAN, with the row index on row 0 and kp_row=4'b1110;
- clear counters and the synchronizer to all ones (no key);
- empty the buffer, with in_cmd=`IC_NONE.
REQ-023 SHALL abandon any in-progress debounce when Reset is asserted mid-operation, with no token issued after release.

Configuration
REQ-024 SHALL use KEYPAD_FIFO_EN.
- Defined: the buffer is a 4-entry FIFO with wrapping 2-bit pointers and a 3-bit count.
- Undefined: the buffer is a single holding register; a press is discarded while a token is pending.

Verification
REQ-025 SHALL cover: press row1/col2 held 300 cycles, then release, with in_ack tied 1 -> exactly one `IC_NUM6 visible for one cycle, then `IC_NONE.
REQ-026 SHALL cover: row0/col0 glitch low for 50 cycles, DEBOUNCE_CYC=200 -> no token, FSM back in SCAN.
REQ-027 SHALL cover: in_ack=0, press keys 1,2,3,+ in sequence -> with FIFO, in_cmd=`IC_NUM1 stable, then ack four times yields 1,2,3,+; without FIFO, only `IC_NUM1 appears.
REQ-028 SHALL cover: row2 col0 and col3 low together -> `IC_NUM7.
REQ-029 SHALL cover: with FIFO, 5 presses and no ack -> the fifth is dropped; 4 acks yield the first four, then `IC_NONE.
REQ-030 SHALL cover: Reset pulsed low mid DEB_PRESS on key 5 -> kp_row=1110, in_cmd=`IC_NONE, no `IC_NUM5 after release.
